// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the multicycle RISC-V control unit.
package riscv_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps funct3/funct7 to the 3-bit ALU operation for R-type and I-ALU.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       is_r,
  output logic [2:0] alu_ctrl
);
  logic [2:0] op000;
  // funct7 only qualifies funct3=000 for register-register ops; immediates always add
  always_comb begin
    op000 = !is_r ? ALU_ADD : funct7 == 7'b0000001 ? ALU_MUL : funct7[5] ? ALU_SUB : ALU_ADD;
    alu_ctrl = funct3 == 3'b000 ? op000 :
               funct3 == 3'b111 ? ALU_AND :
               funct3 == 3'b110 ? ALU_OR  :
               funct3 == 3'b100 ? ALU_XOR :
               funct3 == 3'b001 ? ALU_SLL :
               funct3 == 3'b010 ? ALU_SLT : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: main FSM sequencing fetch/decode/execute/memory/writeback
// and driving datapath enables, mux selects and the ALU operation.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int STATE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             Op,
  input  logic [2:0]             Funct3,
  input  logic [6:0]             Funct7,
  input  logic                   Zero,
  output logic                   PCWrite,
  output logic                   AdrSrc,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic [1:0]             ResultSrc,
  output logic [1:0]             ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic                   RegWrite,
  output logic [1:0]             ImmSrc,
  output logic [2:0]             ALUControl,
  output logic [STATE_WIDTH-1:0] state_o
);
  state_t state, state_n;
  logic [2:0] dec_alu, alu;
  logic pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, src_a, src_b;
  alu_decoder u_dec (
    .funct3  (Funct3),
    .funct7  (Funct7),
    .is_r    (Op == OP_R),
    .alu_ctrl(dec_alu)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_FETCH;
    else        state <= state_n;
  always_comb begin
    state_n    = S_FETCH;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_RS2;
    alu        = ALU_ADD;
    case (state)
      S_FETCH: begin
        state_n    = S_DECODE;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        src_b      = SRCB_FOUR;
        result_src = RES_ALURES;
      end
      S_DECODE: begin
        state_n = Op == OP_LW || Op == OP_SW ? S_MEMADR :
                  Op == OP_R   ? S_EXECR  :
                  Op == OP_I   ? S_EXECI  :
                  Op == OP_BR  ? S_BRANCH :
                  Op == OP_JAL ? S_JAL    : S_FETCH;
        src_a   = SRCA_OLDPC;
        src_b   = SRCB_IMM;
      end
      S_MEMADR: begin
        state_n = Op == OP_LW ? S_MEMREAD : S_MEMWRITE;
        src_a   = SRCA_RS1;
        src_b   = SRCB_IMM;
      end
      S_MEMREAD: begin
        state_n = S_MEMWB;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        state_n = S_ALUWB;
        src_a   = SRCA_RS1;
        alu     = dec_alu;
      end
      S_EXECI: begin
        state_n = S_ALUWB;
        src_a   = SRCA_RS1;
        src_b   = SRCB_IMM;
        alu     = dec_alu;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        src_a    = SRCA_RS1;
        alu      = ALU_SUB;
        pc_write = Funct3 == 3'b000 ? Zero : Funct3 == 3'b001 ? !Zero : 1'b0;
      end
      S_JAL: begin
        state_n  = S_ALUWB;
        src_a    = SRCA_OLDPC;
        src_b    = SRCB_FOUR;
        pc_write = 1'b1;
      end
      default: state_n = S_FETCH;
    endcase
  end
  // reset masks the FETCH decode so nothing is written while rst_n is held low
  assign PCWrite    = rst_n & pc_write;
  assign AdrSrc     = rst_n & adr_src;
  assign MemWrite   = rst_n & mem_write;
  assign IRWrite    = rst_n & ir_write;
  assign RegWrite   = rst_n & reg_write;
  assign ResultSrc  = rst_n ? result_src : 2'b00;
  assign ALUSrcA    = rst_n ? src_a : 2'b00;
  assign ALUSrcB    = rst_n ? src_b : 2'b00;
  assign ALUControl = rst_n ? alu : 3'b000;
  assign ImmSrc     = Op == OP_SW ? IMM_S : Op == OP_BR ? IMM_B : Op == OP_JAL ? IMM_J : IMM_I;
  assign state_o    = STATE_WIDTH'(state);
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Main control FSM for the multicycle RISC-V core; the producer side of the ALU's 3-bit Control interface. It sequences every instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath enables, the mux selects and the ALU operation code. It sits between the instruction register fields and the shared datapath (single memory, single ALU, ALUOut and Data registers).

Parameters:
STATE_WIDTH, 4, width of the state register and of the debug state output.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
Op  in  7  instruction[6:0] from the IR
Funct3  in  3  instruction[14:12]
Funct7  in  7  instruction[31:25]
Zero  in  1  ALU result == 0
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write enable
IRWrite  out  1  IR and OldPC enable
ResultSrc  out  2  Result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  SrcA: 00 = PC, 01 = OldPC, 10 = rs1 register
ALUSrcB  out  2  SrcB: 00 = rs2 register, 01 = ImmExt, 10 = constant 4
RegWrite  out  1  register file write enable
ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
ALUControl  out  3  000 add, 001 sub, 010 mul, 011 and, 100 or, 101 xor, 110 sll, 111 slt
state_o  out  STATE_WIDTH  current state, debug only

Behaviour:
- Reset is asynchronous (rst_n low): state goes to FETCH immediately. While rst_n is low, every enable (PCWrite, MemWrite, IRWrite, RegWrite) is forced to 0. All selects are 0 and ALUControl = 000. Reset mid-instruction abandons the instruction; no partial writes follow.
- FSM states: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10.
- Transitions:
  - FETCH -> DECODE.
  - DECODE on Op:
    - lw 0000011 or sw 0100011 -> MEMADR.
    - R-type 0110011 -> EXECR.
    - I-ALU 0010011 -> EXECI.
    - branch 1100011 -> BRANCH.
    - jal 1101111 -> JAL.
    - any other opcode -> FETCH, with no writes.
  - MEMADR: lw -> MEMREAD; sw -> MEMWRITE.
  - MEMREAD -> MEMWB. EXECR and EXECI -> ALUWB. JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BRANCH -> FETCH.
- Latency per instruction: lw 5 cycles; sw, R-type, I-ALU and jal 4 cycles; branch 3 cycles.
- Outputs per state; any signal not listed is 0:
  - FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALU add.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALU add (computes the branch target into ALUOut).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALU from decoder.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALU from decoder.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite = Zero when Funct3=000 (beq), ~Zero when Funct3=001 (bne), 0 for other Funct3.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
- Only the BRANCH PCWrite and the EXECR/EXECI ALUControl are Mealy terms. They depend on IR fields, which are stable after FETCH.
- ALU decode (combinational):
  - R-type: Funct7=0000001 with Funct3=000 -> mul. Funct3=000 -> sub if Funct7[5]=1, else add. 111 -> and; 110 -> or; 100 -> xor; 001 -> sll; 010 -> slt.
  - I-ALU: same Funct3 map, except 000 is always add.
  - Unlisted Funct3 -> add.
- ImmSrc is purely combinational from Op and valid in every state: lw and I-ALU 00; sw 01; branch 10; jal 11; others 00.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state encodings;
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL);
  - ALU code constants (ALU_ADD through ALU_SLT);
  - mux select constants.
- Sub-module alu_decoder (combinational) takes Funct3, Funct7 and an is_r qualifier and produces the 3-bit ALU code. The FSM muxes its output only in the EXEC states.

Test Plan:
- Reset then lw (Op=0000011): states 0,1,2,3,4,0; IRWrite=1 only in cycle 0; RegWrite=1 only in cycle 4 with ResultSrc=01.
- R-type sub (Funct3=000, Funct7=0100000): EXECR gives ALUControl=001, ALUSrcB=00. Then with Funct7=0000001 -> 010. Then Funct3=010 -> 111.
- beq with Zero=1: PCWrite=1 in BRANCH. Same with Zero=0: PCWrite=0. bne with Zero=0: PCWrite=1. In each case the next state is FETCH.
- sw: MemWrite=1 exactly once, in state 5 with AdrSrc=1; RegWrite never asserts; ImmSrc=01.
- Undefined opcode 1111111: DECODE -> FETCH; no enable asserted in DECODE.
- rst_n low asynchronously in MEMREAD: state_o=0 before the next edge and all enables 0; after release, a normal FETCH occurs.
